// File: rtl/seq_shift_unit_if.sv
// ---------------------------------------------------------------------------
// seq_shift_unit_if
//   Handshake/data bundle between the control FSM (master) and the
//   multi-cycle shift unit (slave).
//   Signals:
//     start     master->slave  request, sampled only while busy=0
//     mode      master->slave  00 LSL, 01 LSR, 10 ASR, 11 ROR
//     shamt     master->slave  shift amount, $clog2(WIDTH) bits
//     data_in   master->slave  operand
//     busy      slave->master  shift in progress
//     done      slave->master  one-cycle completion pulse
//     data_out  slave->master  result, held until the next completion
//     carry_out slave->master  last bit shifted out (SHIFT_CARRY_EN only)
//   Optional feature macro: SHIFT_CARRY_EN
// ---------------------------------------------------------------------------
interface seq_shift_unit_if #(
    parameter int WIDTH = 16
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [1:0]         mode;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data_in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   data_out;
`ifdef SHIFT_CARRY_EN
    logic               carry_out;

    modport master (
        output start, mode, shamt, data_in,
        input  busy, done, data_out, carry_out
    );
    modport slave (
        input  start, mode, shamt, data_in,
        output busy, done, data_out, carry_out
    );
`else
    modport master (
        output start, mode, shamt, data_in,
        input  busy, done, data_out
    );
    modport slave (
        input  start, mode, shamt, data_in,
        output busy, done, data_out
    );
`endif
endinterface

// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
//   Multi-cycle shift/rotate unit (LSL, LSR, ASR, ROR) with a variable shift
//   amount, advancing up to STEP bits per clock. Start/busy/done handshake.
//   Parameters:
//     WIDTH  data width (>= 2)
//     STEP   max bits shifted per cycle (1..WIDTH-1)
//   Ports:
//     CLK    rising-edge clock
//     RST_N  asynchronous active-low reset
//     bus    seq_shift_unit_if slave modport (start, mode, shamt, data_in,
//            busy, done, data_out, and carry_out when enabled)
//   Optional feature macro: SHIFT_CARRY_EN (adds carry_out = last bit out)
// ---------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    seq_shift_unit_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        M_LSL = 2'b00,
        M_LSR = 2'b01,
        M_ASR = 2'b10,
        M_ROR = 2'b11
    } mode_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d, cnt_dec;
    logic [WIDTH-1:0]   step_w;
`ifdef SHIFT_CARRY_EN
    logic               cout_q, cout_d;
    logic               step_c;
`endif

    function automatic logic [WIDTH-1:0] shift1(input mode_e m, input logic [WIDTH-1:0] w);
        case (m)
            M_LSL:   shift1 = {w[WIDTH-2:0], 1'b0};
            M_LSR:   shift1 = {1'b0, w[WIDTH-1:1]};
            M_ASR:   shift1 = {w[WIDTH-1], w[WIDTH-1:1]};
            default: shift1 = {w[0], w[WIDTH-1:1]};
        endcase
    endfunction

    // k = min(STEP, cnt) unit steps, unrolled; the carry tracks the bit
    // leaving on the last step actually applied this cycle.
    always_comb begin
        step_w = work_q;
`ifdef SHIFT_CARRY_EN
        step_c = 1'b0;
`endif
        for (int unsigned i = 0; i < STEP; i++) begin
            if (i < 32'(cnt_q)) begin
`ifdef SHIFT_CARRY_EN
                step_c = (mode_q == M_LSL) ? step_w[WIDTH-1] : step_w[0];
`endif
                step_w = shift1(mode_q, step_w);
            end
        end
        cnt_dec = (32'(cnt_q) > STEP) ? cnt_q - SHAMT_W'(STEP) : '0;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
`ifdef SHIFT_CARRY_EN
        cout_d  = cout_q;
`endif
        case (state_q)
            SHIFT: begin
                work_d = step_w;
                cnt_d  = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = DONE;
                    dout_d  = step_w;
`ifdef SHIFT_CARRY_EN
                    cout_d  = step_c;
`endif
                end
            end
            default: begin
                if (bus.start) begin
                    mode_d = mode_e'(bus.mode);
                    work_d = bus.data_in;
                    cnt_d  = bus.shamt;
                    if (bus.shamt == '0) begin
                        state_d = DONE;
                        dout_d  = bus.data_in;
`ifdef SHIFT_CARRY_EN
                        cout_d  = 1'b0;
`endif
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            mode_q  <= M_LSL;
            work_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
`ifdef SHIFT_CARRY_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
`ifdef SHIFT_CARRY_EN
            cout_q  <= cout_d;
`endif
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = dout_q;
`ifdef SHIFT_CARRY_EN
    assign bus.carry_out = cout_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_unit
//   Two instances of seq_shift_unit (WIDTH=16; STEP=1 and STEP=4), driven
//   with directed and random operations and compared against an arithmetic
//   reference model. Carry checks are included when SHIFT_CARRY_EN is set.
// ---------------------------------------------------------------------------
module tb_seq_shift_unit;

    logic CLK;
    logic RST_N;

    int n_tests = 0;
    int n_fail  = 0;

    logic        start_r [2];
    logic [1:0]  mode_r  [2];
    logic [3:0]  shamt_r [2];
    logic [15:0] din_r   [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] dout_w  [2];
`ifdef SHIFT_CARRY_EN
    logic        cout_w  [2];
`endif

    seq_shift_unit_if #(.WIDTH(16)) bus0 ();
    seq_shift_unit_if #(.WIDTH(16)) bus1 ();

    assign bus0.start   = start_r[0];
    assign bus0.mode    = mode_r[0];
    assign bus0.shamt   = shamt_r[0];
    assign bus0.data_in = din_r[0];
    assign busy_w[0]    = bus0.busy;
    assign done_w[0]    = bus0.done;
    assign dout_w[0]    = bus0.data_out;
    assign bus1.start   = start_r[1];
    assign bus1.mode    = mode_r[1];
    assign bus1.shamt   = shamt_r[1];
    assign bus1.data_in = din_r[1];
    assign busy_w[1]    = bus1.busy;
    assign done_w[1]    = bus1.done;
    assign dout_w[1]    = bus1.data_out;
`ifdef SHIFT_CARRY_EN
    assign cout_w[0]    = bus0.carry_out;
    assign cout_w[1]    = bus1.carry_out;
`endif

    seq_shift_unit #(.WIDTH(16), .STEP(1)) u_dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0)
    );

    seq_shift_unit #(.WIDTH(16), .STEP(4)) u_dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int step_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // Whole-operation reference: result and last bit out from plain arithmetic.
    function automatic void ref_op(input logic [1:0] m, input int s, input logic [15:0] d,
                                   output logic [15:0] r, output logic c);
        logic signed [15:0] sd;
        logic signed [15:0] t;
        int rot;
        sd = d;
        r  = d;
        c  = 1'b0;
        case (m)
            2'd0: begin
                r = (s >= 16) ? 16'h0 : d << s;
                if (s > 0 && s <= 16) c = d[16-s];
            end
            2'd1: begin
                r = (s >= 16) ? 16'h0 : d >> s;
                if (s > 0 && s <= 16) c = d[s-1];
            end
            2'd2: begin
                t = sd >>> s;
                r = (s >= 16) ? {16{d[15]}} : t;
                if (s > 0) c = (s <= 16) ? d[s-1] : d[15];
            end
            default: begin
                rot = s % 16;
                r = (rot == 0) ? d : ((d >> rot) | (d << (16 - rot)));
                if (s > 0) c = r[15];
            end
        endcase
    endfunction

    // Issues one operation; optionally injects a start at edge intr_at or
    // asserts reset just after edge rst_at. Returns #1 after the done edge.
    task automatic run_op(input int u, input logic [1:0] m, input int s, input logic [15:0] d,
                          input int intr_at, input int rst_at, output logic [15:0] exp_r);
        logic [15:0] r;
        logic        c;
        int          n;
        int          lat;
        int          busy_cnt;
        int          i;
        int          seen;
        bit          fin;
        ref_op(m, s, d, r, c);
        exp_r = r;
        n = (s + step_of(u) - 1) / step_of(u);
        @(negedge CLK);
        start_r[u] = 1'b1;
        mode_r[u]  = m;
        shamt_r[u] = 4'(s);
        din_r[u]   = d;
        @(posedge CLK);
        #1;
        start_r[u] = 1'b0;
        i = 0;
        lat = -1;
        busy_cnt = 0;
        fin = 1'b0;
        while (!fin) begin
            if (rst_at == i) begin
                RST_N = 1'b0;
                #1;
                check("rst_mid_busy", 32'(busy_w[u]), 32'd0);
                check("rst_mid_done", 32'(done_w[u]), 32'd0);
                check("rst_mid_dout", 32'(dout_w[u]), 32'd0);
`ifdef SHIFT_CARRY_EN
                check("rst_mid_carry", 32'(cout_w[u]), 32'd0);
`endif
                @(negedge CLK);
                RST_N = 1'b1;
                seen = 0;
                for (int k = 0; k < 12; k++) begin
                    @(posedge CLK);
                    #1;
                    if (done_w[u]) seen++;
                end
                check("rst_no_done", 32'(seen), 32'd0);
                return;
            end
            if (done_w[u]) begin
                lat = i;
                fin = 1'b1;
            end else begin
                if (busy_w[u]) busy_cnt++;
                if (i >= 40) begin
                    fin = 1'b1;
                end else begin
                    if (i + 1 == intr_at) begin
                        start_r[u] = 1'b1;
                        shamt_r[u] = 4'd0;
                        din_r[u]   = 16'h0000;
                    end
                    @(posedge CLK);
                    #1;
                    start_r[u] = 1'b0;
                    i++;
                end
            end
        end
        check("latency", 32'(lat), 32'(n));
        check("busy_cycles", 32'(busy_cnt), 32'(n));
        check("busy_at_done", 32'(busy_w[u]), 32'd0);
        check("data_out", 32'(dout_w[u]), 32'(r));
`ifdef SHIFT_CARRY_EN
        check("carry_out", 32'(cout_w[u]), 32'(c));
`endif
    endtask

    // Operation followed by `gap` idle cycles; gap=0 lets the next start
    // land in the done cycle (back-to-back).
    task automatic do_op(input int u, input logic [1:0] m, input int s, input logic [15:0] d,
                         input int gap);
        logic [15:0] r;
        run_op(u, m, s, d, -1, -1, r);
        for (int g = 0; g < gap; g++) begin
            @(posedge CLK);
            #1;
            check("done_pulse_end", 32'(done_w[u]), 32'd0);
            check("data_held", 32'(dout_w[u]), 32'(r));
        end
    endtask

    initial begin
        logic [15:0] r;
        for (int u = 0; u < 2; u++) begin
            start_r[u] = 1'b0;
            mode_r[u]  = 2'd0;
            shamt_r[u] = 4'd0;
            din_r[u]   = 16'h0;
        end
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset_busy", 32'(busy_w[u]), 32'd0);
            check("reset_done", 32'(done_w[u]), 32'd0);
            check("reset_dout", 32'(dout_w[u]), 32'd0);
`ifdef SHIFT_CARRY_EN
            check("reset_carry", 32'(cout_w[u]), 32'd0);
`endif
        end
        @(negedge CLK);
        RST_N = 1'b1;

        do_op(0, 2'd1, 1,  16'h8001, 1);
        do_op(0, 2'd2, 4,  16'h8000, 1);
        do_op(0, 2'd3, 15, 16'h0001, 1);
        do_op(0, 2'd0, 0,  16'h1234, 1);
        do_op(1, 2'd0, 0,  16'h1234, 1);
        do_op(1, 2'd0, 9,  16'h0001, 1);
        do_op(1, 2'd3, 15, 16'hA5C3, 1);
        do_op(1, 2'd2, 13, 16'h9001, 1);

        run_op(0, 2'd1, 8, 16'hFFFF, 2, -1, r);
        check("ignored_start", 32'(r), 32'h00FF);
        run_op(0, 2'd1, 8, 16'hFFFF, -1, 3, r);

        for (int u = 0; u < 2; u++) begin
            for (int t = 0; t < 40; t++) begin
                do_op(u, 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                      16'($urandom), int'($urandom_range(0, 2)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
